sgx_leaf_seq: RTL and testbench

- Upstream sequencer for the SGX enclave controller.
- Accepts enclave leaf requests (ECREATE/EADD/EINIT/EENTER/EEXIT) over a valid/ready handshake and enforces the enclave lifecycle ordering.
- Drives one-cycle command pulses plus address/data into the enclave controller, and accumulates a 64-bit build measurement.
- Returns one response per request, carrying an error code.

---
 rtl/sgx_leaf_seq.sv | 194 +++++++++++++++++++
 tb/tb_sgx_leaf_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sgx_leaf_seq.sv
// Leaf-request sequencer for the SGX enclave controller: enforces enclave lifecycle
// ordering, issues one-cycle command pulses and accumulates the build measurement.
module sgx_leaf_seq #(
    parameter int MAX_PAGES     = 256,
    parameter int ENTER_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_leaf_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_data_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [2:0]  resp_code_o,
    output logic        ecreate_o,
    output logic        eadd_o,
    output logic        einit_o,
    output logic        eenter_o,
    output logic        eexit_o,
    output logic [63:0] addr_o,
    output logic [63:0] wdata_o,
    input  logic        active_i,
    output logic [1:0]  lstate_o,
    output logic [63:0] mr_o,
    output logic [8:0]  page_cnt_o
);

    typedef enum logic [2:0] {
        PH_IDLE, PH_ISSUE, PH_WAIT, PH_TOUT, PH_RESP
    } phase_t;

    typedef enum logic [1:0] {
        LS_NONE = 2'd0, LS_BUILD = 2'd1, LS_INIT = 2'd2, LS_RUN = 2'd3
    } lstate_t;

    localparam logic [2:0] LEAF_ECREATE = 3'd0;
    localparam logic [2:0] LEAF_EADD    = 3'd1;
    localparam logic [2:0] LEAF_EINIT   = 3'd2;
    localparam logic [2:0] LEAF_EENTER  = 3'd3;
    localparam logic [2:0] LEAF_EEXIT   = 3'd4;

    localparam logic [2:0] RC_OK        = 3'd0;
    localparam logic [2:0] RC_BAD_LEAF  = 3'd1;
    localparam logic [2:0] RC_BAD_STATE = 3'd2;
    localparam logic [2:0] RC_FULL      = 3'd3;
    localparam logic [2:0] RC_TIMEOUT   = 3'd4;

    localparam int          WW       = $clog2(ENTER_TIMEOUT + 1);
    localparam logic [8:0]  CNT_MAX  = 9'(MAX_PAGES);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ENTER_TIMEOUT - 1);

    phase_t        phase_q, phase_d;
    lstate_t       lstate_q;
    logic [2:0]    leaf_q;
    logic [63:0]   addr_q, data_q, mr_q;
    logic [8:0]    cnt_q;
    logic [2:0]    code_q;
    logic [WW-1:0] wait_q;

    logic [2:0]    issue_code;
    logic          legal;
    logic          accept;
    logic          wait_expired;

    assign accept       = (phase_q == PH_IDLE) && req_valid_i;
    assign wait_expired = (wait_q == WAIT_LAST);

    // Legality of the registered request against the current lifecycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        issue_code = RC_OK;
        unique case (leaf_q)
            LEAF_ECREATE: if (lstate_q != LS_NONE) issue_code = RC_BAD_STATE;
            LEAF_EADD: begin
                if (lstate_q != LS_BUILD)  issue_code = RC_BAD_STATE;
                else if (cnt_q == CNT_MAX) issue_code = RC_FULL;
            end
            LEAF_EINIT:  if (lstate_q != LS_BUILD || cnt_q == '0) issue_code = RC_BAD_STATE;
            LEAF_EENTER: if (lstate_q != LS_INIT) issue_code = RC_BAD_STATE;
            LEAF_EEXIT:  if (lstate_q != LS_RUN)  issue_code = RC_BAD_STATE;
            default:     issue_code = RC_BAD_LEAF;
        endcase
    end

    assign legal = (issue_code == RC_OK);

    // Handshake phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) phase_q <= PH_IDLE;
        else        phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_IDLE:  if (req_valid_i) phase_d = PH_ISSUE;
            PH_ISSUE: phase_d = (legal && leaf_q == LEAF_EENTER) ? PH_WAIT : PH_RESP;
            PH_WAIT: begin
                if (active_i)          phase_d = PH_RESP;
                else if (wait_expired) phase_d = PH_TOUT;
            end
            PH_TOUT:  phase_d = PH_RESP;
            PH_RESP:  phase_d = PH_IDLE;
            default:  phase_d = PH_IDLE;
        endcase
    end

    // Pulses are decoded from the phase register, so an async reset removes them at once.
    always_comb begin
        req_ready_o  = (phase_q == PH_IDLE);
        resp_valid_o = (phase_q == PH_RESP);
        resp_code_o  = resp_valid_o ? code_q : RC_OK;
        resp_err_o   = resp_valid_o && (code_q != RC_OK);
        ecreate_o    = 1'b0;
        eadd_o       = 1'b0;
        einit_o      = 1'b0;
        eenter_o     = 1'b0;
        eexit_o      = (phase_q == PH_TOUT);
        if (phase_q == PH_ISSUE && legal) begin
            unique case (leaf_q)
                LEAF_ECREATE: ecreate_o = 1'b1;
                LEAF_EADD:    eadd_o    = 1'b1;
                LEAF_EINIT:   einit_o   = 1'b1;
                LEAF_EENTER:  eenter_o  = 1'b1;
                LEAF_EEXIT:   eexit_o   = 1'b1;
                default:      ;
            endcase
        end
    end

    // Request capture, response code and enter-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            code_q <= RC_OK;
            wait_q <= '0;
        end else begin
            if (accept) begin
                leaf_q <= req_leaf_i;
                addr_q <= req_addr_i;
                data_q <= req_data_i;
            end
            unique case (phase_q)
                PH_ISSUE: begin
                    code_q <= issue_code;
                    wait_q <= '0;
                end
                PH_WAIT: wait_q <= wait_q + 1'b1;
                PH_TOUT: code_q <= RC_TIMEOUT;
                default: ;
            endcase
        end
    end

    // Lifecycle, measurement and page count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate_q <= LS_NONE;
            mr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            if (lstate_q == LS_RUN && !active_i) lstate_q <= LS_INIT;
            if (phase_q == PH_WAIT && active_i)  lstate_q <= LS_RUN;
            if (phase_q == PH_ISSUE && legal) begin
                unique case (leaf_q)
                    LEAF_ECREATE: begin
                        lstate_q <= LS_BUILD;
                        mr_q     <= '0;
                        cnt_q    <= '0;
                    end
                    LEAF_EADD: begin
                        cnt_q <= cnt_q + 1'b1;
                        mr_q  <= {mr_q[56:0], mr_q[63:57]} ^ addr_q ^ data_q;
                    end
                    LEAF_EINIT: lstate_q <= LS_INIT;
                    LEAF_EEXIT: lstate_q <= LS_INIT;
                    default:    ;
                endcase
            end
        end
    end

    assign addr_o     = addr_q;
    assign wdata_o    = data_q;
    assign lstate_o   = lstate_q;
    assign mr_o       = mr_q;
    assign page_cnt_o = cnt_q;

endmodule

// File: tb/tb_sgx_leaf_seq.sv
// Scoreboard bench for sgx_leaf_seq: directed requests push expected response codes,
// a negedge monitor pops and compares every response strobe.
module tb_sgx_leaf_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_leaf_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic        resp_valid_o, resp_err_o;
    logic [2:0]  resp_code_o;
    logic        ecreate_o, eadd_o, einit_o, eenter_o, eexit_o;
    logic [63:0] addr_o, wdata_o;
    logic        active_i = 1'b0;
    logic [1:0]  lstate_o;
    logic [63:0] mr_o;
    logic [8:0]  page_cnt_o;

    sgx_leaf_seq #(.MAX_PAGES(256), .ENTER_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_leaf_i(req_leaf_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_code_o(resp_code_o),
        .ecreate_o(ecreate_o), .eadd_o(eadd_o), .einit_o(einit_o),
        .eenter_o(eenter_o), .eexit_o(eexit_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .active_i(active_i),
        .lstate_o(lstate_o), .mr_o(mr_o), .page_cnt_o(page_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_pulse_cyc = -1, last_resp_cyc = -1, eenter_cyc = -1, eexit_cyc = -1;
    int resp_cnt = 0;
    int pc[5] = '{0, 0, 0, 0, 0};
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pulse bookkeeping and scoreboard comparison of every response.
    always @(negedge clk) begin
        if (ecreate_o) begin pc[0]++; last_pulse_cyc = cyc; end
        if (eadd_o)    begin pc[1]++; last_pulse_cyc = cyc; end
        if (einit_o)   begin pc[2]++; last_pulse_cyc = cyc; end
        if (eenter_o)  begin pc[3]++; last_pulse_cyc = cyc; eenter_cyc = cyc; end
        if (eexit_o)   begin pc[4]++; last_pulse_cyc = cyc; eexit_cyc = cyc; end
        if (resp_valid_o) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got code %0d with no request pending", resp_code_o);
            end else begin
                automatic logic [2:0] e = exp_q.pop_front();
                check("resp_code", 64'(resp_code_o), 64'(e));
                check("resp_err", 64'(resp_err_o), 64'(e != 3'd0));
            end
        end else begin
            check("idle_code_zero", {60'd0, resp_err_o, resp_code_o}, 64'd0);
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Issue one request; pmask bits [0..4] = ecreate,eadd,einit,eenter,eexit pulses expected.
    task automatic do_req(input logic [2:0] leaf, input logic [63:0] addr, input logic [63:0] data,
                          input logic [2:0] code, input logic [4:0] pmask);
        int snap[5];
        int start;
        for (int k = 0; k < 5; k++) snap[k] = pc[k];
        start = resp_cnt;
        exp_q.push_back(code);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_leaf_i  = leaf;
        req_addr_i  = addr;
        req_data_i  = data;
        acc_cyc     = cyc;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int i = 0; i < 40 && resp_cnt == start; i++) @(posedge clk);
        #1;
        check("resp_seen", 64'(resp_cnt - start), 64'd1);
        for (int k = 0; k < 5; k++)
            check($sformatf("pulse_cnt[%0d]", k), 64'(pc[k] - snap[k]), 64'(pmask[k]));
    endtask

    // EENTER with active_i raised one cycle after the eenter_o pulse.
    task automatic enter_with_active();
        fork
            do_req(3'd3, 64'h0, 64'h0, 3'd0, 5'b01000);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!eenter_o && n < 20) begin @(negedge clk); n++; end
                @(negedge clk) active_i = 1'b1;
            end
        join
    endtask

    logic [63:0] exp_mr;
    logic [63:0] a, d;

    initial begin
        apply_reset();
        #1;
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_lstate", 64'(lstate_o), 64'd0);
        check("rst_mr", mr_o, 64'd0);
        check("rst_cnt", 64'(page_cnt_o), 64'd0);
        check("rst_pulses", {59'd0, ecreate_o, eadd_o, einit_o, eenter_o, eexit_o}, 64'd0);

        // ECREATE: pulse in the cycle after accept, response two cycles after.
        do_req(3'd0, 64'h1000, 64'h0, 3'd0, 5'b00001);
        check("ecreate_pulse_cyc", 64'(last_pulse_cyc), 64'(acc_cyc + 1));
        check("ecreate_resp_cyc", 64'(last_resp_cyc), 64'(acc_cyc + 2));
        check("ecreate_lstate", 64'(lstate_o), 64'd1);
        check("ecreate_cnt", 64'(page_cnt_o), 64'd0);
        check("ecreate_mr", mr_o, 64'd0);
        check("ecreate_addr", addr_o, 64'h1000);

        do_req(3'd2, 64'h0, 64'h0, 3'd2, 5'b00000);   // EINIT with no pages
        check("einit_early_lstate", 64'(lstate_o), 64'd1);

        do_req(3'd1, 64'h0100, 64'hA5, 3'd0, 5'b00010);
        check("eadd_addr", addr_o, 64'h0100);
        check("eadd_wdata", wdata_o, 64'hA5);
        check("eadd_cnt", 64'(page_cnt_o), 64'd1);
        check("eadd_mr", mr_o, 64'h01A5);

        do_req(3'd2, 64'h0, 64'h0, 3'd0, 5'b00100);
        check("einit_lstate", 64'(lstate_o), 64'd2);

        do_req(3'd1, 64'h2000, 64'h77, 3'd2, 5'b00000);  // EADD in INIT
        check("eadd_init_mr", mr_o, 64'h01A5);
        check("eadd_init_cnt", 64'(page_cnt_o), 64'd1);
        do_req(3'd0, 64'h3000, 64'h0, 3'd2, 5'b00000);   // ECREATE in INIT
        check("ecreate_init_lstate", 64'(lstate_o), 64'd2);

        enter_with_active();
        check("enter_ok_lstate", 64'(lstate_o), 64'd3);

        do_req(3'd4, 64'h0, 64'h0, 3'd0, 5'b10000);
        check("eexit_lstate", 64'(lstate_o), 64'd2);
        active_i = 1'b0;

        // EENTER with no active response: eexit after the 8-cycle window.
        do_req(3'd3, 64'h0, 64'h0, 3'd4, 5'b11000);
        check("timeout_eexit_gap", 64'(eexit_cyc - eenter_cyc), 64'd9);
        check("timeout_lstate", 64'(lstate_o), 64'd2);

        enter_with_active();
        check("enter2_lstate", 64'(lstate_o), 64'd3);
        @(negedge clk) active_i = 1'b0;
        @(posedge clk); #1;
        check("active_drop_lstate", 64'(lstate_o), 64'd2);

        do_req(3'd6, 64'h0, 64'h0, 3'd1, 5'b00000);
        check("bad_leaf_lstate", 64'(lstate_o), 64'd2);

        // Fill to MAX_PAGES, then one more must report FULL.
        apply_reset();
        do_req(3'd0, 64'h8000, 64'h0, 3'd0, 5'b00001);
        exp_mr = '0;
        for (int i = 0; i < 256; i++) begin
            a = 64'(i) << 12;
            d = 64'h0123_4567_89AB_CDEF ^ 64'(i);
            exp_mr = {exp_mr[56:0], exp_mr[63:57]} ^ a ^ d;
            do_req(3'd1, a, d, 3'd0, 5'b00010);
        end
        check("full_cnt", 64'(page_cnt_o), 64'd256);
        check("full_mr", mr_o, exp_mr);
        do_req(3'd1, 64'hF000, 64'h1, 3'd3, 5'b00000);
        check("over_cnt", 64'(page_cnt_o), 64'd256);
        check("over_mr", mr_o, exp_mr);

        // Reset during the ISSUE cycle of an EADD.
        apply_reset();
        do_req(3'd0, 64'h9000, 64'h0, 3'd0, 5'b00001);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_leaf_i  = 3'd1;
        req_addr_i  = 64'h4000;
        req_data_i  = 64'h5;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        check("midrst_eadd_high", 64'(eadd_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_eadd_drop", 64'(eadd_o), 64'd0);
        check("midrst_no_resp", 64'(resp_valid_o), 64'd0);
        check("midrst_lstate", 64'(lstate_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_ready", 64'(req_ready_o), 64'd1);
        check("midrst_cnt", 64'(page_cnt_o), 64'd0);
        check("pending_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
